uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit-side frame controller for the UART TX path. It sits directly upstream of the TX serializer and owns the frame sequence.
- Accepts a parallel byte through a valid/ready handshake and latches it with the parity settings.
- Drives the serializer's load/enable and presents the held word to it.
- Muxes start, data, parity and stop bits onto the line.
- clk is the bit clock: one cycle equals one bit period.

Parameters:
DATA_WIDTH, 8, width of the payload word; must match the serializer's data width.

Ports:
clk  input  1  bit-rate clock
rst  input  1  asynchronous active-low reset
p_data_in  input  DATA_WIDTH  byte to transmit
data_valid  input  1  p_data_in is valid; accepted when data_ready=1
par_en  input  1  1 = insert parity bit; sampled at accept
par_typ  input  1  0 = even parity, 1 = odd parity; sampled at accept
ser_done  input  1  from serializer: its counter is zero (idle or last bit)
ser_data  input  1  from serializer: current data bit (LSB first)
ser_en  output  1  to serializer: load/start strobe
ser_p_data  output  DATA_WIDTH  to serializer: held transmit word
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress
data_ready  output  1  controller can accept a word this cycle

Behaviour:
- Reset is decided as rst, asynchronous, active-low; the clock is clk.
- Reset (rst=0, asynchronous), at any time including mid-frame:
  - state=IDLE; held word, parity flags and parity bit cleared.
  - Outputs: tx_out=1, busy=0, ser_en=0, data_ready=1, ser_p_data=0.
- States: IDLE, START, DATA, PARITY, STOP, held in a registered state.
  - tx_out and busy are combinational decodes of the state register plus ser_data.
- Accept: on a rising edge where data_valid=1 and the state is IDLE or STOP:
  - Capture p_data_in, par_en and par_typ.
  - Compute parity bit = (^p_data_in) XOR par_typ.
  - Next state = START.
- IDLE: tx_out=1, busy=0, data_ready=1. Without data_valid, stay in IDLE.
- START: tx_out=0, busy=1, ser_en=1 (only state asserting ser_en), data_ready=0. Next state = DATA unconditionally.
- DATA:
  - tx_out=ser_data, busy=1, data_ready=0.
  - While ser_done=0, stay in DATA.
  - When ser_done=1, the current cycle carries the last data bit. Next state = PARITY if latched par_en=1, else STOP.
  - ser_en must stay 0 in DATA, otherwise the serializer reloads on its last bit.
  - Result: exactly DATA_WIDTH DATA cycles, LSB first.
- PARITY: tx_out = latched parity bit, busy=1, data_ready=0. Next state = STOP.
- STOP:
  - tx_out=1, busy=1, data_ready=1.
  - If data_valid=1, accept the new word and go to START; no idle bit between frames, busy stays 1.
  - Otherwise go to IDLE.
- Frame length: 1 + DATA_WIDTH + par_en + 1 cycles.
  - First frame bit (start) appears on the cycle after the accept edge.
- data_valid in START, DATA or PARITY is ignored: no capture, no state change. The upstream source must hold the word until data_ready=1.
- Changes to par_en/par_typ mid-frame do not affect the frame in flight.
- ser_p_data is the held register; it is stable from the accept edge through the end of STOP.
- DATA_WIDTH=1 is legal: the serializer reports ser_done=1 on the first DATA cycle, giving a single DATA cycle.

Test Plan:
- Reset → tx_out=1, busy=0, data_ready=1, ser_en=0. Idle 10 cycles: tx_out stays 1.
- 0xA5, par_en=0 → tx_out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; ser_en high in the START cycle only; busy high for exactly 10 cycles.
- 0xA5, par_en=1, par_typ=0 → parity bit 0 before stop (11-cycle frame). Repeat with par_typ=1 → parity bit 1.
- 0x00 accepted, data_valid held with 0xFF during STOP → tx_out = 0, 0×8, 1, 0, 1×8, 1; no idle gap; busy continuously high.
- data_valid pulse with 0x3C during DATA of an 0x81 frame → ignored; line shows only 0x81; data_ready=0 until STOP.
- rst asserted during DATA bit 3 → tx_out=1 and busy=0 immediately (asynchronous). After release, a new 0x55 frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a word over valid/ready, drives the
// serializer load strobe, and sequences start, data, parity and stop bits onto the line.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  data_ready
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    par_en_reg;
    logic                    par_bit;
    logic                    accept;

    // A word is taken only when the line is idle or finishing its stop bit,
    // which lets frames run back to back without an idle bit in between.
    assign accept     = data_valid && ((state == IDLE) || (state == STOP));
    assign ser_p_data = data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = START;
                end
            end
            START: begin
                next_state = DATA;
            end
            DATA: begin
                if (ser_done) begin
                    next_state = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: begin
                next_state = STOP;
            end
            STOP: begin
                next_state = accept ? START : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Parity is resolved at accept time so later par_en/par_typ changes cannot
    // disturb the frame already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg   <= '0;
            par_en_reg <= 1'b0;
            par_bit    <= 1'b0;
        end else if (accept) begin
            data_reg   <= p_data_in;
            par_en_reg <= par_en;
            par_bit    <= (^p_data_in) ^ par_typ;
        end
    end

    always_comb begin
        tx_out     = 1'b1;
        busy       = 1'b0;
        ser_en     = 1'b0;
        data_ready = 1'b0;
        unique case (state)
            IDLE: begin
                data_ready = 1'b1;
            end
            START: begin
                tx_out = 1'b0;
                busy   = 1'b1;
                ser_en = 1'b1;
            end
            DATA: begin
                tx_out = ser_data;
                busy   = 1'b1;
            end
            PARITY: begin
                tx_out = par_bit;
                busy   = 1'b1;
            end
            STOP: begin
                busy       = 1'b1;
                data_ready = 1'b1;
            end
            default: begin
                tx_out     = 1'b1;
                busy       = 1'b0;
                ser_en     = 1'b0;
                data_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a behavioural serializer feeds the DUT and
// a scoreboard of expected per-bit line states is compared cycle by cycle.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] p_data_in;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic          ser_done;
    logic          ser_data;
    logic          ser_en;
    logic [DW-1:0] ser_p_data;
    logic          tx_out;
    logic          busy;
    logic          data_ready;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data_in  (p_data_in),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .ser_p_data (ser_p_data),
        .tx_out     (tx_out),
        .busy       (busy),
        .data_ready (data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer model: load on ser_en, then shift LSB first, counting down to zero.
    logic [DW-1:0] sh_reg;
    logic [3:0]    sh_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_reg <= '0;
            sh_cnt <= '0;
        end else if (ser_en) begin
            sh_reg <= ser_p_data;
            sh_cnt <= 4'(DW - 1);
        end else if (sh_cnt != 0) begin
            sh_reg <= sh_reg >> 1;
            sh_cnt <= sh_cnt - 4'd1;
        end
    end

    assign ser_done = (sh_cnt == 4'd0);
    assign ser_data = sh_reg[0];

    typedef struct {
        logic          tx;
        logic          busy;
        logic          ser_en;
        logic          ready;
        logic [DW-1:0] word;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
        logic          exp_par;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_entry(input logic tx, input logic bsy, input logic sen,
                              input logic rdy, input logic [DW-1:0] word);
        exp_t e;
        e.tx     = tx;
        e.busy   = bsy;
        e.ser_en = sen;
        e.ready  = rdy;
        e.word   = word;
        sb_q.push_back(e);
    endtask

    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pbit);
        push_entry(1'b0, 1'b1, 1'b1, 1'b0, d);
        for (int i = 0; i < DW; i++) begin
            push_entry(d[i], 1'b1, 1'b0, 1'b0, d);
        end
        if (pe) begin
            push_entry(pbit, 1'b1, 1'b0, 1'b0, d);
        end
        push_entry(1'b1, 1'b1, 1'b0, 1'b1, d);
    endtask

    always @(negedge clk) begin
        if (rst && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_output("tx_out", 32'(tx_out), 32'(e.tx));
            check_output("busy", 32'(busy), 32'(e.busy));
            check_output("ser_en", 32'(ser_en), 32'(e.ser_en));
            check_output("data_ready", 32'(data_ready), 32'(e.ready));
            check_output("ser_p_data", 32'(ser_p_data), 32'(e.word));
        end
    end

    // Presents a word from a falling edge and holds it until the DUT takes it.
    task automatic apply_stimulus(input logic [DW-1:0] d, input logic pe, input logic pt,
                                  input bit push, input logic pbit);
        int waited;
        waited = 0;
        @(negedge clk);
        p_data_in  = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        while (!data_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!data_ready) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL accept_timeout: data_ready stuck at %0b, expected 1", data_ready);
            data_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        if (push) begin
            push_frame(d, pe, pbit);
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb_q.size() > 0 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    vec_t       vecs[9];
    logic [9:0] a5_pat;

    initial begin
        vecs = '{
            '{8'hA5, 1'b0, 1'b0, 1'b0},
            '{8'hA5, 1'b1, 1'b0, 1'b0},
            '{8'hA5, 1'b1, 1'b1, 1'b1},
            '{8'h01, 1'b1, 1'b0, 1'b1},
            '{8'h01, 1'b1, 1'b1, 1'b0},
            '{8'hFF, 1'b1, 1'b1, 1'b1},
            '{8'h7E, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b0, 1'b1, 1'b0},
            '{8'h80, 1'b1, 1'b0, 1'b1}
        };
        a5_pat = 10'b1101001010;

        rst        = 1'b0;
        p_data_in  = '0;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        #2;
        check_output("rst_tx_out", 32'(tx_out), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_data_ready", 32'(data_ready), 32'd1);
        check_output("rst_ser_en", 32'(ser_en), 32'd0);
        check_output("rst_ser_p_data", 32'(ser_p_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("idle_tx_out", 32'(tx_out), 32'd1);
            check_output("idle_busy", 32'(busy), 32'd0);
        end

        // Literal line pattern for 0xA5 without parity, followed by one idle cycle.
        apply_stimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push_entry(a5_pat[i], 1'b1, (i == 0), (i == 9), 8'hA5);
        end
        push_entry(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
        drain();

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].data, vecs[i].pe, vecs[i].pt, 1'b1, vecs[i].exp_par);
            push_entry(1'b1, 1'b0, 1'b0, 1'b1, vecs[i].data);
            drain();
        end

        // Back-to-back: 0xFF held valid through the 0x00 frame is taken in STOP.
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        push_entry(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        drain();

        // A valid pulse with parity changes during DATA must be ignored.
        apply_stimulus(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        push_entry(1'b1, 1'b0, 1'b0, 1'b1, 8'h81);
        repeat (3) @(negedge clk);
        p_data_in  = 8'h3C;
        par_en     = 1'b1;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        check_output("pulse_data_ready", 32'(data_ready), 32'd0);
        @(negedge clk);
        data_valid = 1'b0;
        drain();
        @(negedge clk);
        check_output("pulse_no_frame_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of data bit 3 of an 0xA5 frame.
        apply_stimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check_output("bit3_tx_out", 32'(tx_out), 32'd0);
        check_output("bit3_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_output("async_rst_tx_out", 32'(tx_out), 32'd1);
        check_output("async_rst_busy", 32'(busy), 32'd0);
        check_output("async_rst_ser_en", 32'(ser_en), 32'd0);
        check_output("async_rst_data_ready", 32'(data_ready), 32'd1);
        check_output("async_rst_ser_p_data", 32'(ser_p_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply_stimulus(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        push_entry(1'b1, 1'b0, 1'b0, 1'b1, 8'h55);
        drain();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
